des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES subkey generator for the encrypt/decrypt datapath. It loads a 64-bit key and produces the 16 48-bit round keys one per `advance` handshake. In encrypt mode it emits them in forward order, K1..K16, using left rotations. In decrypt mode it emits them in reverse order, K16..K1, using right rotations. It sits beside the initial/final permutation stage and feeds the Feistel round engine.

## Interface
Parameters: none. DES widths are fixed.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `n_rst`  in  1  reset, synchronous, active-low.
- `key_in`  in  64  DES key, bit 1 (FIPS numbering) = `key_in[63]`; parity bits ignored.
- `load`  in  1  single-cycle pulse; captures `key_in` and `decrypt`, starts a new schedule.
- `decrypt`  in  1  sampled only on `load`: 0 = forward order, 1 = reverse order.
- `advance`  in  1  consumer has used the current `round_key`; step to the next key.
- `round_key`  out  48  current subkey = PC-2(C,D); 48'h0 whenever `key_valid` = 0.
- `round_num`  out  4  index of the current round, 0..15, in emission order; 0 when idle.
- `key_valid`  out  1  `round_key` is valid.
- `done`  out  1  one-cycle pulse after the 16th key is consumed.

## Operation
- Internal state:
  - 28-bit `c_reg` and `d_reg`.
  - 4-bit round counter.
  - mode flag.
  - FSM with states IDLE and ACTIVE.
- Shift schedule, indexed by DES round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE + `load`:
  - C,D are set from PC-1(`key_in`).
  - Encrypt mode: each half is rotated left by 1 in the same cycle (round 1 shift), so K1 is presented.
  - Decrypt mode: C,D are left unrotated (C16D16 = C0D0), so K16 is presented.
  - Counter ← 0, FSM → ACTIVE.
- ACTIVE + `advance` with counter r < 15:
  - Encrypt: rotate left by shift[r+2].
  - Decrypt: rotate right by shift[16−r], which takes CD(16−r) to CD(15−r).
  - Counter ← r+1.
- ACTIVE + `advance` with r = 15:
  - `done` ← 1 for one cycle.
  - FSM → IDLE; `key_valid` ← 0; C,D are cleared.
- Boundary conditions:
  - `load` in ACTIVE restarts from round 0 with the new key and mode. `load` takes priority over a simultaneous `advance`.
  - `advance` in IDLE is ignored.
  - `done` and a `load` in the same cycle are legal; the next schedule starts normally.
  - Reset (`n_rst` = 0 at an edge) aborts any schedule:
    - Reset state: FSM IDLE, C,D = 0, counter 0, mode 0.
    - Output values: `key_valid` 0, `done` 0, `round_key` 0, `round_num` 0.
- `round_key` is combinational PC-2 of the registered C,D, gated by `key_valid`.

## Timing
- `load` at edge N → `key_valid` = 1 with the first key valid after edge N (cycle N+1).
- Each `advance` sampled at an edge presents the next key in the following cycle, i.e. one key per cycle with `advance` held high.
- With `advance` held continuously, 16 keys occupy cycles N+1..N+16. `done` is high in cycle N+17 with `key_valid` = 0.
- The key stays stable for as long as `advance` is low; there is no timeout.
- `decrypt` and `key_in` are don't-care except in the `load` cycle.

## Structure
- Shared package `des_pkg`:
  - PC-1 index table (56 entries) and PC-2 index table (48 entries).
  - Shift-schedule constant array.
  - FSM state enum.
  - Width localparams: key 64, half 28, subkey 48.
- Sub-module `des_pc2`: combinational, 56-bit C‖D → 48-bit subkey. Reused by the round engine's testbench reference model.
- Top level contains the FSM, counter and rotate logic.

## Test plan
- Key 64'h133457799BBCDFF1, `decrypt` = 0, `load` then hold `advance`:
  - K1 = 48'h1B02EFFC7072, K2 = 48'h79AED9DBC9E5, K16 = 48'hCB3D8B0E17F5.
  - `done` in cycle N+17.
- Same key, `decrypt` = 1: first key 48'hCB3D8B0E17F5, second = forward K15, last = 48'h1B02EFFC7072. The full sequence is the exact reverse of the encrypt run.
- Stall: hold `advance` low for 5 cycles at round 7. `round_key` and `round_num` = 7 stay constant; the sequence resumes unchanged.
- `load` with a new key at round 9, coincident with `advance`: round 0 of the new key is presented and no `done` is emitted for the old run.
- `n_rst` low at round 4: next cycle all outputs 0 and state IDLE; a later `advance` has no effect.
- Key 64'h0 and key 64'hFFFFFFFFFFFFFFFF: all 16 subkeys are 48'h0 and 48'hFFFFFFFFFFFF respectively, in both modes.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, shift schedule, widths and the
// key-schedule FSM encoding.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;

  // FIPS 46-3 tables, 1-based bit numbers with bit 1 as the MSB.
  localparam int PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry i is the rotate amount for DES round i+1.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sched_state_e;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++)
      r[6'(CD_W-1-i)] = k[6'(KEY_W-PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted choice 2: compresses the 56-bit C||D register pair into a 48-bit
// round subkey. Purely combinational.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++)
      subkey[6'(SUBKEY_W-1-i)] = cd[6'(CD_W-PC2_TAB[i])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one round key per advance, forward order
// with left rotations for encrypt, reverse order with right rotations for decrypt.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                load,
  input  logic                decrypt,
  input  logic                advance,
  output logic [SUBKEY_W-1:0] round_key,
  output logic [3:0]          round_num,
  output logic                key_valid,
  output logic                done
);

  // Handshake: key_valid marks round_key/round_num as valid; the consumer
  // pulses advance while key_valid is high to accept the key, and the next key
  // appears the following cycle. advance without key_valid is ignored.

  sched_state_e         state;
  logic [HALF_W-1:0]    c_reg, d_reg;
  logic [3:0]           cnt;
  logic                 mode;
  logic                 valid_q;
  logic                 done_q;

  logic [CD_W-1:0]      cd_init;
  logic [1:0]           shamt_enc, shamt_dec;
  logic [SUBKEY_W-1:0]  pc2_out;

  assign cd_init = pc1(key_in);
  // Encrypt at round index r uses DES round r+2; decrypt uses round 16-r.
  assign shamt_enc = SHIFT_SCHED[cnt + 4'd1];
  assign shamt_dec = SHIFT_SCHED[4'd15 - cnt];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      c_reg   <= '0;
      d_reg   <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state   <= ACTIVE;
        valid_q <= 1'b1;
        cnt     <= '0;
        mode    <= decrypt;
        if (decrypt) begin
          c_reg <= cd_init[CD_W-1:HALF_W];
          d_reg <= cd_init[HALF_W-1:0];
        end else begin
          c_reg <= rotl28(cd_init[CD_W-1:HALF_W], 2'd1);
          d_reg <= rotl28(cd_init[HALF_W-1:0], 2'd1);
        end
      end else if (state == ACTIVE && advance) begin
        if (cnt == 4'd15) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          c_reg   <= '0;
          d_reg   <= '0;
          cnt     <= '0;
          mode    <= 1'b0;
        end else begin
          cnt <= cnt + 4'd1;
          if (mode) begin
            c_reg <= rotr28(c_reg, shamt_dec);
            d_reg <= rotr28(d_reg, shamt_dec);
          end else begin
            c_reg <= rotl28(c_reg, shamt_enc);
            d_reg <= rotl28(d_reg, shamt_enc);
          end
        end
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_reg, d_reg}),
    .subkey (pc2_out)
  );

  assign round_key = valid_q ? pc2_out : '0;
  assign round_num = cnt;
  assign key_valid = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1
// key plus all-zero and all-one keys.
module tb_des_key_schedule;
  import des_pkg::*;

  logic                clk = 1'b0;
  logic                n_rst;
  logic [KEY_W-1:0]    key_in;
  logic                load;
  logic                decrypt;
  logic                advance;
  logic [SUBKEY_W-1:0] round_key;
  logic [3:0]          round_num;
  logic                key_valid;
  logic                done;

  int checks = 0;
  int errors = 0;

  // Observation word: {done, key_valid, round_num, round_key}
  logic [53:0] exp_q[$];

  localparam logic [KEY_W-1:0] MAIN_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] ENC_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_in    (key_in),
    .load      (load),
    .decrypt   (decrypt),
    .advance   (advance),
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .done      (done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // kind: 0 = main key, 1 = all-zero key, 2 = all-one key
  function automatic logic [47:0] exp_key(input int kind, input int r, input logic dec);
    if (kind == 1) return 48'h0;
    if (kind == 2) return 48'hFFFFFFFFFFFF;
    return dec ? ENC_K[15-r] : ENC_K[r];
  endfunction

  task automatic push_key(input int kind, input logic dec, input int r);
    exp_q.push_back({1'b0, 1'b1, 4'(r), exp_key(kind, r, dec)});
  endtask

  task automatic push_done();
    exp_q.push_back({1'b1, 1'b0, 4'd0, 48'h0});
  endtask

  task automatic push_run(input int kind, input logic dec);
    for (int r = 0; r < 16; r++) push_key(kind, dec, r);
    push_done();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [KEY_W-1:0] k, input logic dec, input logic adv);
    load    = 1'b1;
    key_in  = k;
    decrypt = dec;
    advance = adv;
    step();
    load    = 1'b0;
    key_in  = ~k;
    decrypt = ~dec;
  endtask

  task automatic run_full(input logic [KEY_W-1:0] k, input logic dec);
    do_load(k, dec, 1'b0);
    advance = 1'b1;
    repeat (16) step();
    advance = 1'b0;
    step();
    step();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [53:0] act, e;
    if (n_rst === 1'b1 || n_rst === 1'b0) begin
      act = {done, key_valid, round_num, round_key};
      if (key_valid || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_obs got done=%0b valid=%0b rnd=%0d key=%h want none",
                   done, key_valid, round_num, round_key);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL obs got done=%0b valid=%0b rnd=%0d key=%h want done=%0b valid=%0b rnd=%0d key=%h",
                     act[53], act[52], act[51:48], act[47:0], e[53], e[52], e[51:48], e[47:0]);
          end
        end
      end else if (round_key !== '0 || round_num !== '0) begin
        checks++;
        errors++;
        $display("FAIL idle_outputs got rnd=%0d key=%h want rnd=0 key=0", round_num, round_key);
      end
    end
  end

  // stimulus
  initial begin
    n_rst   = 1'b0;
    load    = 1'b0;
    decrypt = 1'b0;
    advance = 1'b0;
    key_in  = '0;
    repeat (3) step();
    check("rst_valid", 64'(key_valid), 64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_key",   64'(round_key), 64'd0);
    check("rst_rnum",  64'(round_num), 64'd0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    n_rst = 1'b1;
    advance = 1'b1;
    step();
    advance = 1'b0;
    step();

    // forward and reverse full schedules
    push_run(0, 1'b0);
    run_full(MAIN_KEY, 1'b0);
    push_run(0, 1'b1);
    run_full(MAIN_KEY, 1'b1);

    // stall at round 7
    for (int r = 0; r < 7; r++) push_key(0, 1'b0, r);
    repeat (6) push_key(0, 1'b0, 7);
    for (int r = 8; r < 16; r++) push_key(0, 1'b0, r);
    push_done();
    do_load(MAIN_KEY, 1'b0, 1'b0);
    advance = 1'b1;
    repeat (7) step();
    advance = 1'b0;
    repeat (5) step();
    advance = 1'b1;
    repeat (9) step();
    advance = 1'b0;
    repeat (2) step();

    // reload at round 9 with coincident advance, switching to decrypt
    for (int r = 0; r < 10; r++) push_key(0, 1'b0, r);
    push_run(0, 1'b1);
    do_load(MAIN_KEY, 1'b0, 1'b0);
    advance = 1'b1;
    repeat (9) step();
    do_load(MAIN_KEY, 1'b1, 1'b1);
    repeat (16) step();
    advance = 1'b0;
    repeat (2) step();

    // reset in the middle of a schedule
    for (int r = 0; r < 5; r++) push_key(0, 1'b0, r);
    do_load(MAIN_KEY, 1'b0, 1'b0);
    advance = 1'b1;
    repeat (4) step();
    advance = 1'b0;
    n_rst = 1'b0;
    step();
    check("midrst_valid", 64'(key_valid), 64'd0);
    check("midrst_key",   64'(round_key), 64'd0);
    check("midrst_rnum",  64'(round_num), 64'd0);
    check("midrst_done",  64'(done),      64'd0);
    check("midrst_state", 64'(dut.state), 64'(IDLE));
    n_rst = 1'b1;
    advance = 1'b1;
    repeat (3) step();
    check("idle_adv_valid", 64'(key_valid), 64'd0);
    check("idle_adv_done",  64'(done),      64'd0);
    advance = 1'b0;
    step();

    // degenerate keys in both modes
    push_run(1, 1'b0);
    run_full(64'h0, 1'b0);
    push_run(1, 1'b1);
    run_full(64'h0, 1'b1);
    push_run(2, 1'b0);
    run_full(64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_run(2, 1'b1);
    run_full(64'hFFFFFFFFFFFFFFFF, 1'b1);

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
